// File: rtl/reset_sequencer_if.sv
// Reset-sequencer side-band: soft-reset handshake plus the staged reset outputs.
// The sequencer drives through the master modport; a consumer/requester uses slave.
interface reset_sequencer_if #(
  parameter int unsigned NUM_STAGES = 4
);
  logic                  soft_rst_req_i;
  logic [NUM_STAGES-1:0] rst_n_o;
  logic                  rst_done_o;
  logic                  soft_rst_ack_o;

  modport master (
    input  soft_rst_req_i,
    output rst_n_o,
    output rst_done_o,
    output soft_rst_ack_o
  );

  modport slave (
    output soft_rst_req_i,
    input  rst_n_o,
    input  rst_done_o,
    input  soft_rst_ack_o
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset generator: synchronised release of NUM_STAGES active-low resets, one group
// every STAGE_DLY cycles, with a soft-reset request that re-runs the assert/release sequence.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned STAGE_DLY   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               reset_n,
  reset_sequencer_if.master bus
);

  localparam int unsigned CntW = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;
  localparam int unsigned IdxW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(STAGE_DLY - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    StHold,
    StRelease,
    StDone,
    StAssert
  } state_e;

  state_e                state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  rst_sync;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic                  done_q, done_d;
  logic                  ack_q, ack_d;
  logic                  cnt_last;

  // Release synchroniser: reset_n assertion clears it asynchronously, release ripples in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];
  assign cnt_last = (cnt_q == CntLast);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StHold;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHold: begin
        if (rst_sync) state_d = StRelease;
      end
      StRelease: begin
        if (cnt_last && (idx_q == IdxLast)) state_d = StDone;
      end
      StDone: begin
        if (bus.soft_rst_req_i) state_d = StAssert;
      end
      StAssert: begin
        if (cnt_last) state_d = StRelease;
      end
      default: state_d = StHold;
    endcase
  end

  // Output and datapath next values; every output is taken straight from a flop.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    ack_d   = 1'b0;
    unique case (state_q)
      StHold: begin
        rst_n_d = '0;
        done_d  = 1'b0;
        if (rst_sync) begin
          cnt_d = '0;
          idx_d = '0;
        end
      end
      StRelease: begin
        if (cnt_last) begin
          cnt_d = '0;
          idx_d = idx_q + IdxW'(1);
          for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (idx_q == IdxW'(k)) rst_n_d[k] = 1'b1;
          end
          if (idx_q == IdxLast) done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (bus.soft_rst_req_i) begin
          rst_n_d = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      StAssert: begin
        if (cnt_last) begin
          cnt_d = '0;
          idx_d = '0;
          ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        rst_n_d = '0;
        done_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.rst_n_o        = rst_n_q;
  assign bus.rst_done_o     = done_q;
  assign bus.soft_rst_ack_o = ack_q;

  // Released stages always form a contiguous run starting at stage 0.
  a_thermometer : assert property (@(posedge clk) disable iff (!reset_n)
    ((rst_n_q & (rst_n_q + NUM_STAGES'(1))) == '0));

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Generates staged, synchronously released active-low resets for downstream register groups.
- Assertion of the upstream reset clears all outputs asynchronously. Release is synchronised, then staged one group at a time, stage 0 first.
- Also accepts a software soft-reset request that re-runs the assert/release sequence without the board reset.
- Sits at the top of a subsystem and feeds the reset pins of datapath flops.

Parameters:
- NUM_STAGES, 4: number of downstream reset outputs; legal range 1..16.
- STAGE_DLY, 8: cycles between successive stage releases, also the soft-reset hold time; legal range 1..256.
- SYNC_STAGES, 2: depth of the reset-release synchroniser; legal range 2..4.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- soft_rst_req_i  input  1  level soft-reset request; sampled only in DONE.
- rst_n_o  output  NUM_STAGES  active-low resets to downstream groups; bit k is stage k.
- rst_done_o  output  1  high while all stages are released.
- soft_rst_ack_o  output  1  one-cycle pulse when a soft reset's hold phase ends.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: on reset_n low, immediately and independent of clk:
  - rst_n_o = all 0; rst_done_o = 0; soft_rst_ack_o = 0.
  - synchroniser chain = 0; state = HOLD; cnt = 0; idx = 0.
- All flops use an async clear from reset_n. No output is combinational from inputs.
- Synchroniser:
  - sync[0] <= 1 and sync[i] <= sync[i-1] each edge.
  - rst_sync = sync[SYNC_STAGES-1].
- FSM states: HOLD, RELEASE, DONE, ASSERT.
- HOLD:
  - All outputs low.
  - At an edge with rst_sync = 1: go to RELEASE, cnt <= 0, idx <= 0.
  - Entry into RELEASE occurs on the (SYNC_STAGES+1)th rising edge after reset_n rises.
- RELEASE:
  - cnt increments each edge.
  - At an edge with cnt == STAGE_DLY-1: rst_n_o[idx] <= 1, cnt <= 0, idx <= idx+1.
  - If idx == NUM_STAGES-1 at that edge: also rst_done_o <= 1 and go to DONE.
- Release timing:
  - With RELEASE entered at edge E, stage k rises at edge E + (k+1)*STAGE_DLY.
  - rst_done_o rises with the last stage.
  - Already-released stages stay high; the order is strictly 0 to NUM_STAGES-1.
- DONE:
  - Outputs hold.
  - At an edge with soft_rst_req_i = 1: go to ASSERT; rst_n_o <= all 0, rst_done_o <= 0, cnt <= 0.
  - All stages assert in the same cycle.
- ASSERT:
  - cnt increments each edge.
  - At an edge with cnt == STAGE_DLY-1: go to RELEASE, cnt <= 0, idx <= 0, soft_rst_ack_o <= 1 for exactly one cycle.
  - The hold therefore lasts STAGE_DLY cycles.
- soft_rst_req_i outside DONE: ignored, not queued.
- Request still high when DONE is re-entered: a new soft reset starts on the next edge. Requesters must drop req after seeing ack.
- reset_n low mid-sequence (any state): immediate return to reset values. The full sequence restarts after release.
- STAGE_DLY = 1: one stage is released per cycle, and ASSERT lasts one cycle.
- cnt width: max(1, $clog2(STAGE_DLY)). idx width: max(1, $clog2(NUM_STAGES)).
- No glitches on rst_n_o; each bit is driven directly by a flop.

Test Plan:
- Power-on release (defaults): reset_n low 3 cycles, then high just after an edge. Edge numbering counts that edge as 0.
  - rst_n_o = 4'b0001 at edge 11, 4'b0011 at edge 19, 4'b0111 at edge 27, 4'b1111 at edge 35.
  - rst_done_o rises at edge 35.
- Async assert mid-release: drop reset_n between edges 20 and 21.
  - rst_n_o = 0 and rst_done_o = 0 within the same cycle, without a clock edge.
  - After release, the timing of the power-on release case repeats exactly.
- Soft reset: in DONE, pulse soft_rst_req_i for 1 cycle, sampled at edge S.
  - rst_n_o = 0 after edge S.
  - soft_rst_ack_o high for exactly one cycle after edge S+8.
  - Stage k rises at edge S+8+8*(k+1).
- Request ignored outside DONE: hold soft_rst_req_i high during RELEASE, drop it before DONE.
  - No ASSERT occurs and no ack pulse.
  - rst_n_o reaches 4'b1111 on the normal schedule.
- Sticky request: hold soft_rst_req_i high continuously from DONE.
  - Back-to-back soft resets; ack pulses every 8+32+1 = 41 cycles.
  - Each cycle passes through 4'b1111 for one cycle, with rst_done_o = 1 for one cycle.
- Corner configuration NUM_STAGES=1, STAGE_DLY=1, SYNC_STAGES=2:
  - rst_n_o rises at edge 4 after reset_n release.
  - A soft reset gives rst_n_o low for 2 cycles, with ack in the second.
